// File: rtl/prog_loader_if.sv
// Byte stream into the program loader: valid/ready, one byte per transfer.
// Master is the byte source; slave is the loader, which never ties ready to valid.
interface prog_loader_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/prog_loader.sv
// Loads a framed byte stream (SYNC, LEN, payload, CSUM) into instruction memory and releases the core on a good checksum.
// Writes appear one cycle after each payload accept; in_ready is a registered function of state and stalls freely on in_valid gaps.
module prog_loader #(
    parameter int               ADDR_W    = 8,
    parameter int               DATA_W    = 8,
    parameter logic [DATA_W-1:0] SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    prog_loader_if.slave      in_if,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);
    localparam int CNT_W = DATA_W + 1;
    localparam int AW1   = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [AW1-1:0]    addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              accept;
    logic [DATA_W-1:0] sum_next;

    assign accept   = in_if.in_valid & in_ready_q;
    assign sum_next = sum_q + in_if.in_data;

    always_comb begin
        state_d     = state_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_SYNC;
                    addr_d  = '0;
                    cnt_d   = '0;
                end
            end
            S_SYNC: begin
                if (accept && in_if.in_data == SYNC_BYTE) begin
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (accept) begin
                    // A zero length byte encodes the full 2^DATA_W payload.
                    cnt_d   = (in_if.in_data == '0) ? {1'b1, {DATA_W{1'b0}}}
                                                     : {1'b0, in_if.in_data};
                    sum_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    // The extra address bit blocks any write past the top of memory.
                    mem_we_d    = ~addr_q[ADDR_W];
                    mem_addr_d  = addr_q[ADDR_W-1:0];
                    mem_wdata_d = in_if.in_data;
                    sum_d       = sum_next;
                    addr_d      = addr_q + AW1'(1);
                    cnt_d       = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (accept) begin
                    state_d = (sum_next == '0) ? S_DONE : S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status outputs are registered copies of the next state so they change with it.
        in_ready_d = (state_d == S_SYNC) || (state_d == S_LEN) ||
                     (state_d == S_DATA) || (state_d == S_CSUM);
        done_d     = (state_d == S_DONE);
        error_d    = (state_d == S_ERR);
        cpu_hold_d = (state_d != S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            addr_q      <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_hold_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            done_q      <= done_d;
            error_q     <= error_d;
            cpu_hold_q  <= cpu_hold_d;
        end
    end

    assign in_if.in_ready = in_ready_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign cpu_hold       = cpu_hold_q;
    assign done           = done_q;
    assign error          = error_q;
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frames with hand-computed checksums, an 8-bit memory model fed by the write port.
module tb_prog_loader;
    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_hold;
    logic       done;
    logic       error;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] mem [256];
    logic [7:0] pl [$];

    prog_loader_if #(.DATA_W(8)) in_if ();

    prog_loader #(.ADDR_W(8), .DATA_W(8), .SYNC_BYTE(8'hA5)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_if    (in_if),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the cycle after the accept.
    task automatic send_byte(input logic [7:0] b, input bit payload, input logic [7:0] exp_addr);
        int waitc;
        waitc = 0;
        in_if.in_valid = 1'b1;
        in_if.in_data  = b;
        while (in_if.in_ready !== 1'b1 && waitc < 64) begin
            @(posedge clk);
            @(negedge clk);
            waitc++;
        end
        if (in_if.in_ready !== 1'b1) begin
            check_eq("rdy_timeout", 32'(in_if.in_ready), 32'd1);
            in_if.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_if.in_valid = 1'b0;
        check_eq("we", 32'(mem_we), 32'(payload));
        if (payload) begin
            check_eq("addr", 32'(mem_addr), 32'(exp_addr));
            check_eq("wdata", 32'(mem_wdata), 32'(b));
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("we_gap", 32'(mem_we), 32'd0);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] len, input logic [7:0] csum, input bit good, input bit gaps);
        send_byte(8'hA5, 1'b0, 8'h00);
        send_byte(len, 1'b0, 8'h00);
        for (int i = 0; i < pl.size(); i++) begin
            if (gaps) begin
                idle(int'($urandom_range(0, 3)));
                if (i == 2) begin
                    pulse_start();
                    check_eq("rdy_after_start_in_data", 32'(in_if.in_ready), 32'd1);
                end
            end
            send_byte(pl[i], 1'b1, 8'(i));
            if (i == pl.size() - 1) check_eq("hold_at_last_we", 32'(cpu_hold), 32'd1);
        end
        send_byte(csum, 1'b0, 8'h00);
        check_eq("done", 32'(done), 32'(good));
        check_eq("error", 32'(error), 32'(!good));
        check_eq("cpu_hold", 32'(cpu_hold), 32'(!good));
        check_eq("rdy_end", 32'(in_if.in_ready), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_rdy"}, 32'(in_if.in_ready), 32'd0);
        check_eq({tag, "_we"}, 32'(mem_we), 32'd0);
        check_eq({tag, "_addr"}, 32'(mem_addr), 32'd0);
        check_eq({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
        check_eq({tag, "_hold"}, 32'(cpu_hold), 32'd1);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_error"}, 32'(error), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        reset          = 1'b0;
        start          = 1'b0;
        in_if.in_valid = 1'b0;
        in_if.in_data  = 8'h00;
        #7;
        check_reset_vals("rst");
        @(negedge clk);
        reset = 1'b1;
        idle(2);
        check_eq("idle_rdy", 32'(in_if.in_ready), 32'd0);

        // Basic 3-byte frame, valid held high.
        pulse_start();
        check_eq("t1_hold", 32'(cpu_hold), 32'd1);
        pl = '{8'h11, 8'h22, 8'h33};
        run_frame(8'h03, 8'h9A, 1'b1, 1'b0);

        // Leading garbage before sync is dropped.
        pulse_start();
        check_eq("t2_done_clr", 32'(done), 32'd0);
        check_eq("t2_hold", 32'(cpu_hold), 32'd1);
        send_byte(8'h00, 1'b0, 8'h00);
        send_byte(8'h7F, 1'b0, 8'h00);
        send_byte(8'h5A, 1'b0, 8'h00);
        pl = '{8'h40};
        run_frame(8'h01, 8'hC0, 1'b1, 1'b0);
        check_eq("t2_mem0", 32'(mem[0]), 32'h40);
        check_eq("t2_mem1_kept", 32'(mem[1]), 32'h22);

        // Bad checksum, then recovery.
        pulse_start();
        pl = '{8'h01, 8'h02};
        run_frame(8'h02, 8'hFF, 1'b0, 1'b0);
        check_eq("t3_mem0", 32'(mem[0]), 32'h01);
        check_eq("t3_mem1", 32'(mem[1]), 32'h02);
        pulse_start();
        check_eq("t3_err_clr", 32'(error), 32'd0);
        pl = '{8'h05};
        run_frame(8'h01, 8'hFB, 1'b1, 1'b0);
        check_eq("t3b_mem0", 32'(mem[0]), 32'h05);
        check_eq("t3b_mem1_kept", 32'(mem[1]), 32'h02);

        // LEN=0 gives a full 256-byte frame.
        pulse_start();
        pl = {};
        for (int i = 0; i < 256; i++) pl.push_back(8'(i));
        run_frame(8'h00, 8'h80, 1'b1, 1'b0);
        check_eq("t4_mem0", 32'(mem[0]), 32'h00);
        check_eq("t4_mem128", 32'(mem[128]), 32'h80);
        check_eq("t4_mem255", 32'(mem[255]), 32'hFF);

        // Gaps on in_valid and a start pulse in DATA.
        pulse_start();
        pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_frame(8'h04, 8'hC8, 1'b1, 1'b1);
        check_eq("t5_mem0", 32'(mem[0]), 32'hDE);
        check_eq("t5_mem1", 32'(mem[1]), 32'hAD);
        check_eq("t5_mem3", 32'(mem[3]), 32'hEF);
        check_eq("t5_mem4_kept", 32'(mem[4]), 32'h04);

        // Reset lands while a write strobe is high.
        pulse_start();
        send_byte(8'hA5, 1'b0, 8'h00);
        send_byte(8'h04, 1'b0, 8'h00);
        send_byte(8'h01, 1'b1, 8'h00);
        send_byte(8'h02, 1'b1, 8'h01);
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("mid");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        in_if.in_valid = 1'b1;
        in_if.in_data  = 8'hA5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("post_rst_rdy", 32'(in_if.in_ready), 32'd0);
        check_eq("post_rst_we", 32'(mem_we), 32'd0);
        check_eq("post_rst_hold", 32'(cpu_hold), 32'd1);
        in_if.in_valid = 1'b0;
        check_eq("t6_mem0", 32'(mem[0]), 32'h01);
        check_eq("t6_mem1_dropped", 32'(mem[1]), 32'hAD);

        pulse_start();
        pl = '{8'h77};
        run_frame(8'h01, 8'h89, 1'b1, 1'b0);
        check_eq("t7_mem0", 32'(mem[0]), 32'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
